// File: rtl/irig_pkg.sv
// Shared IRIG decoder types: symbol codes, default timing constants and FSM encodings.
package irig_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO    = 2'b00,
    SYM_ONE     = 2'b01,
    SYM_MARK    = 2'b10,
    SYM_INVALID = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } sym_state_t;

  typedef enum logic [1:0] {
    FRM_HUNT   = 2'd0,
    FRM_M1     = 2'd1,
    FRM_LOCKED = 2'd2
  } frm_state_t;

  localparam int DEF_TICKS_PER_SYM = 10;
  localparam int DEF_W_ZERO        = 2;
  localparam int DEF_W_ONE         = 5;
  localparam int DEF_W_MARK        = 8;
  localparam int DEF_TOL           = 1;
  localparam int DEF_MARK_SPACING  = 10;
  localparam int DEF_MARKS_PER_FRM = 10;

  function automatic logic in_window(int v, int nom, int tol);
    return (v >= nom - tol) && (v <= nom + tol);
  endfunction

endpackage

// File: rtl/irig_pw_classifier.sv
// Synchronises the IRIG line, measures high time and period per symbol on each
// sample tick, and reports one ZERO/ONE/MARKER/INVALID code per symbol.
module irig_pw_classifier
  import irig_pkg::*;
#(
  parameter int TICKS_PER_SYM = DEF_TICKS_PER_SYM,
  parameter int W_ZERO        = DEF_W_ZERO,
  parameter int W_ONE         = DEF_W_ONE,
  parameter int W_MARK        = DEF_W_MARK,
  parameter int TOL           = DEF_TOL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       irig_in,
  output logic       emit,
  output sym_t       emit_type,
  output logic       sym_valid,
  output logic [1:0] sym_type
);

  localparam int CW = $clog2(TICKS_PER_SYM + TOL + 2);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX   = '1;
  localparam cnt_t HI_LIMIT  = cnt_t'(W_MARK + TOL);
  localparam cnt_t PER_LIMIT = cnt_t'(TICKS_PER_SYM + TOL);

  logic       sync1_q, sync2_q;
  logic       run_q;
  logic       tick;
  sym_state_t st_q, st_d;
  cnt_t       hi_q, hi_d;
  cnt_t       per_q, per_d;
  logic       sym_valid_q, sym_valid_d;
  sym_t       sym_type_q, sym_type_d;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic sym_t classify(cnt_t hi, cnt_t per);
    sym_t t;
    t = SYM_INVALID;
    if (in_window(int'(per), TICKS_PER_SYM, TOL)) begin
      if (in_window(int'(hi), W_ZERO, TOL))      t = SYM_ZERO;
      else if (in_window(int'(hi), W_ONE, TOL))  t = SYM_ONE;
      else if (in_window(int'(hi), W_MARK, TOL)) t = SYM_MARK;
    end
    return t;
  endfunction

  // run_q masks a tick landing on the same edge that releases reset.
  assign tick = sample_tick & run_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    st_d      = st_q;
    hi_d      = hi_q;
    per_d     = per_q;
    emit      = 1'b0;
    emit_type = SYM_INVALID;
    if (tick) begin
      case (st_q)
        ST_IDLE: begin
          if (sync2_q) begin
            st_d  = ST_HIGH;
            hi_d  = cnt_t'(1);
            per_d = cnt_t'(1);
          end
        end
        ST_HIGH: begin
          per_d = sat_inc(per_q);
          if (sync2_q) begin
            hi_d = sat_inc(hi_q);
            if (hi_d > HI_LIMIT) begin
              emit = 1'b1;
              st_d = ST_STUCK;
            end
          end else begin
            st_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (sync2_q) begin
            // Rising edge closes the symbol; per_q already holds its full period.
            emit      = 1'b1;
            emit_type = classify(hi_q, per_q);
            st_d      = ST_HIGH;
            hi_d      = cnt_t'(1);
            per_d     = cnt_t'(1);
          end else begin
            per_d = sat_inc(per_q);
            if (per_d > PER_LIMIT) begin
              emit = 1'b1;
              st_d = ST_IDLE;
            end
          end
        end
        ST_STUCK: begin
          if (!sync2_q) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
    sym_valid_d = emit;
    sym_type_d  = emit ? emit_type : sym_type_q;
  end

  // NOTE: non-blocking assignments so every flop captures its pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      run_q       <= 1'b0;
      st_q        <= ST_IDLE;
      hi_q        <= '0;
      per_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_type_q  <= SYM_ZERO;
    end else begin
      sync1_q     <= irig_in;
      sync2_q     <= sync1_q;
      run_q       <= 1'b1;
      st_q        <= st_d;
      hi_q        <= hi_d;
      per_q       <= per_d;
      sym_valid_q <= sym_valid_d;
      sym_type_q  <= sym_type_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_type  = sym_type_q;

endmodule

// File: rtl/irig_frame_decoder.sv
// IRIG frame decoder top: symbol classifier plus frame-sync FSM that tracks the
// double reference marker, reports bit position and declares/loses lock.
module irig_frame_decoder
  import irig_pkg::*;
#(
  parameter int TICKS_PER_SYM = DEF_TICKS_PER_SYM,
  parameter int W_ZERO        = DEF_W_ZERO,
  parameter int W_ONE         = DEF_W_ONE,
  parameter int W_MARK        = DEF_W_MARK,
  parameter int TOL           = DEF_TOL,
  parameter int MARK_SPACING  = DEF_MARK_SPACING,
  parameter int MARKS_PER_FRM = DEF_MARKS_PER_FRM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       irig_in,
  output logic       sym_valid,
  output logic [1:0] sym_type,
  output logic       locked,
  output logic       frame_start,
  output logic [6:0] bit_pos,
  output logic       sync_err
);

  localparam int UW = (MARK_SPACING > 1) ? $clog2(MARK_SPACING) : 1;
  localparam int MW = (MARKS_PER_FRM > 1) ? $clog2(MARKS_PER_FRM) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(MARK_SPACING - 1);
  localparam logic [MW-1:0] MARK_LAST = MW'(MARKS_PER_FRM - 1);

  logic          emit;
  sym_t          emit_type;
  frm_state_t    frm_q, frm_d;
  logic [UW-1:0] units_q, units_d, units_nx;
  logic [MW-1:0] marks_q, marks_d, marks_nx;
  logic          locked_q, locked_d;
  logic          frame_start_q, frame_start_d;
  logic          sync_err_q, sync_err_d;
  logic          at_ref, exp_mark, sym_ok;

  irig_pw_classifier #(
    .TICKS_PER_SYM (TICKS_PER_SYM),
    .W_ZERO        (W_ZERO),
    .W_ONE         (W_ONE),
    .W_MARK        (W_MARK),
    .TOL           (TOL)
  ) u_classifier (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .irig_in     (irig_in),
    .emit        (emit),
    .emit_type   (emit_type),
    .sym_valid   (sym_valid),
    .sym_type    (sym_type)
  );

  // Position the incoming symbol would occupy, and whether a marker belongs there.
  always_comb begin
    units_nx = (units_q == UNIT_LAST) ? '0 : units_q + 1'b1;
    marks_nx = marks_q;
    if (units_q == UNIT_LAST) marks_nx = (marks_q == MARK_LAST) ? '0 : marks_q + 1'b1;
    at_ref   = (units_nx == '0) && (marks_nx == '0);
    exp_mark = at_ref || (units_nx == UNIT_LAST);
    sym_ok   = (emit_type != SYM_INVALID) && ((emit_type == SYM_MARK) == exp_mark);
  end

  always_comb begin
    frm_d         = frm_q;
    units_d       = units_q;
    marks_d       = marks_q;
    locked_d      = locked_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    if (emit) begin
      case (frm_q)
        FRM_HUNT: begin
          if (emit_type == SYM_MARK) frm_d = FRM_M1;
        end
        FRM_M1: begin
          if (emit_type == SYM_MARK) begin
            frm_d         = FRM_LOCKED;
            locked_d      = 1'b1;
            frame_start_d = 1'b1;
            units_d       = '0;
            marks_d       = '0;
          end else begin
            frm_d = FRM_HUNT;
          end
        end
        FRM_LOCKED: begin
          if (sym_ok) begin
            units_d       = units_nx;
            marks_d       = marks_nx;
            frame_start_d = at_ref;
          end else begin
            frm_d      = FRM_HUNT;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
            units_d    = '0;
            marks_d    = '0;
          end
        end
        default: frm_d = FRM_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frm_q         <= FRM_HUNT;
      units_q       <= '0;
      marks_q       <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frm_q         <= frm_d;
      units_q       <= units_d;
      marks_q       <= marks_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign bit_pos     = 7'(marks_q) * 7'(MARK_SPACING) + 7'(units_q);

endmodule

// File: tb/tb_irig_frame_decoder.sv
// Directed bench for irig_frame_decoder: symbol-level behavioural model checked every
// cycle, plus hand-computed expectations for classes, period errors, lock, loss and wrap.
module tb_irig_frame_decoder;

  localparam int P     = 10;
  localparam int TOL   = 1;
  localparam int WZ    = 2;
  localparam int WO    = 5;
  localparam int WM    = 8;
  localparam int MS    = 10;
  localparam int FRAME = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       irig_in = 1'b0;
  logic       sym_valid, locked, frame_start, sync_err;
  logic [1:0] sym_type;
  logic [6:0] bit_pos;

  int checks = 0;
  int errors = 0;

  irig_frame_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .irig_in     (irig_in),
    .sym_valid   (sym_valid),
    .sym_type    (sym_type),
    .locked      (locked),
    .frame_start (frame_start),
    .bit_pos     (bit_pos),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: run lengths of the current high and low phases, frame position as an int.
  logic model_v = 1'b0;
  int   m_mode = 0;  // 0 waiting for high, 1 inside a symbol, 2 stuck high
  int   m_hi = 0, m_lo = 0, m_pos = 0;
  bit   m_lock = 0, m_m1 = 0, m_run = 0;
  logic exp_valid = 0, exp_fs = 0, exp_se = 0;
  logic [1:0] exp_type = 0;
  logic em;
  logic [1:0] et;

  int         n_sym = 0, n_fs = 0, n_se = 0;
  logic [1:0] last_type = 0;

  function automatic logic [1:0] class_of(int hi, int per);
    int w [3];
    w = '{WZ, WO, WM};
    if (per < P - TOL || per > P + TOL) return 2'd3;
    for (int k = 0; k < 3; k++)
      if (hi >= w[k] - TOL && hi <= w[k] + TOL) return 2'(k);
    return 2'd3;
  endfunction

  task automatic model_sym(input logic s, output logic e, output logic [1:0] t);
    e = 0;
    t = 2'd3;
    if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_hi = 1; m_lo = 0; end
    end else if (m_mode == 2) begin
      if (!s) m_mode = 0;
    end else if (m_lo == 0) begin
      if (s) begin
        m_hi++;
        if (m_hi > WM + TOL) begin e = 1; m_mode = 2; end
      end else m_lo = 1;
    end else if (s) begin
      e = 1; t = class_of(m_hi, m_hi + m_lo); m_hi = 1; m_lo = 0;
    end else begin
      m_lo++;
      if (m_hi + m_lo > P + TOL) begin e = 1; m_mode = 0; end
    end
  endtask

  task automatic model_frame(input logic [1:0] t);
    int  np;
    bit  want;
    if (m_lock) begin
      np   = (m_pos + 1) % FRAME;
      want = (np == 0) || (np % MS == MS - 1);
      if (t != 2'd3 && ((t == 2'd2) == want)) begin
        m_pos  = np;
        exp_fs = (np == 0);
      end else begin
        m_lock = 0; m_pos = 0; exp_se = 1;
      end
    end else if (t == 2'd2) begin
      if (m_m1) begin m_lock = 1; m_pos = 0; exp_fs = 1; m_m1 = 0; end
      else m_m1 = 1;
    end else m_m1 = 0;
  endtask

  // Model update on each edge, then compare all outputs just after it.
  always @(posedge clk) begin
    exp_valid = 0; exp_fs = 0; exp_se = 0;
    if (!reset) begin
      m_mode = 0; m_lock = 0; m_m1 = 0; m_pos = 0; m_run = 0; exp_type = 0;
    end else begin
      if (sample_tick && m_run) begin
        model_sym(model_v, em, et);
        if (em) begin
          exp_valid = 1; exp_type = et;
          model_frame(et);
        end
      end
      m_run = 1;
    end
    #1;
    check("outputs", {sym_valid, (exp_valid ? sym_type : 2'b00), locked, frame_start, sync_err, bit_pos},
          {exp_valid, (exp_valid ? exp_type : 2'b00), m_lock, exp_fs, exp_se, 7'(m_lock ? m_pos : 0)});
    if (sym_valid) begin n_sym++; last_type = sym_type; end
    if (frame_start) n_fs++;
    if (sync_err) n_se++;
  end

  task automatic put_sample(input logic v);
    @(negedge clk) irig_in = v;
    @(negedge clk);
    @(negedge clk) begin sample_tick = 1'b1; model_v = v; end
    @(negedge clk) sample_tick = 1'b0;
  endtask

  task automatic send_sym(input int h, input int l);
    repeat (h) put_sample(1'b1);
    repeat (l) put_sample(1'b0);
  endtask

  task automatic send_type(input int t);
    case (t)
      0:       send_sym(WZ, P - WZ);
      1:       send_sym(WO, P - WO);
      default: send_sym(WM, P - WM);
    endcase
  endtask

  int hs [7] = '{2, 5, 8, 3, 4, 6, 7};
  int ex [7] = '{0, 1, 2, 0, 1, 1, 2};
  int n0, f0, s0;

  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) put_sample(1'(i % 2));
    check("reset_outputs", {sym_valid, sym_type, locked, frame_start, sync_err, bit_pos}, 0);
    @(negedge clk) reset = 1'b1;
    n0 = n_sym;
    repeat (20) put_sample(1'b0);
    check("idle_no_symbol", n_sym - n0, 0);

    for (int i = 0; i < 7; i++) begin
      send_sym(hs[i], P - hs[i]);
      if (i > 0) check($sformatf("class_high%0d", hs[i-1]), last_type, ex[i-1]);
    end
    send_sym(5, 5);
    check("class_high7", last_type, 2);

    n0 = n_sym;
    send_sym(5, 7);
    check("period12_count", n_sym - n0, 2);
    check("period12_type", last_type, 3);

    n0 = n_sym;
    repeat (15) put_sample(1'b1);
    check("stuck_one_invalid", n_sym - n0, 1);
    check("stuck_type", last_type, 3);
    repeat (3) put_sample(1'b0);
    check("stuck_quiet", n_sym - n0, 1);

    f0 = n_fs;
    send_type(2); send_type(2);
    send_type(1);
    check("lock_locked", locked, 1);
    check("lock_pos0", bit_pos, 0);
    check("lock_frame_start", n_fs - f0, 1);
    for (int p = 2; p <= 8; p++) send_type(p % 2);
    send_type(2);
    send_type(0);
    check("pos9_locked", locked, 1);
    check("pos9_bit_pos", bit_pos, 9);

    s0 = n_se;
    for (int p = 11; p <= 18; p++) send_type(p % 2);
    send_type(1);
    send_type(0);
    check("loss_sync_err", n_se - s0, 1);
    check("loss_unlocked", locked, 0);
    check("loss_bit_pos", bit_pos, 0);

    f0 = n_fs;
    send_type(2); send_type(2);
    for (int p = 1; p <= 148; p++)
      send_type((p % FRAME == 0 || p % MS == MS - 1) ? 2 : p % 2);
    check("wrap_frame_starts", n_fs - f0, 2);
    check("wrap_locked", locked, 1);
    check("wrap_bit_pos47", bit_pos, 47);

    @(negedge clk) reset = 1'b0;
    #1;
    check("midreset_locked", locked, 0);
    check("midreset_bit_pos", bit_pos, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n0 = n_sym;
    repeat (5) put_sample(1'b0);
    check("post_reset_quiet", n_sym - n0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
